// File: rtl/pdm_mic_model_pkg.sv
// Shared audio definitions for the PDM microphone model: FSM states,
// the PCM-to-unsigned offset and the default geometry.
package pdm_mic_model_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pdm_state_e;

  localparam logic [15:0] PCM_OFFSET         = 16'h8000;
  localparam int          DECIM_DEFAULT      = 128;
  localparam int          FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/pdm_sample_fifo.sv
// PCM sample buffer for the PDM model; a push into an empty FIFO is not
// visible at dout until the following cycle.
module pdm_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pdm_mic_model.sv
// Behavioural PDM microphone: PCM samples from a small FIFO are turned into
// a first-order sigma-delta bitstream, one bit per receiver mic_clk edge.
//
//   state   | meaning
//   IDLE    | no sample playing; modulator runs at midscale (0,1,0,1...)
//   RUN     | playing cur_sample, DECIM bits per sample
module pdm_mic_model
  import pdm_mic_model_pkg::*;
#(
  parameter int   DECIM      = DECIM_DEFAULT,
  parameter int   FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter logic LR_CHANNEL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mic_clk,
  input  logic        mic_lr_sel,
  output logic        mic_data,
  output logic        mic_data_oe,
  input  logic        pcm_valid,
  input  logic [15:0] pcm_data,
  output logic        pcm_ready,
  output logic        underrun,
  output logic        running
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  pdm_state_e    state, state_next;
  logic [CW-1:0] bit_cnt, bit_cnt_next;
  logic [15:0]   cur_sample, cur_next;
  logic [15:0]   acc;
  logic [15:0]   u;
  logic [16:0]   sum;
  logic          mic_clk_d;
  logic          mic_edge;
  logic          underrun_next;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [15:0]   fifo_dout;

  assign mic_edge  = mic_clk & ~mic_clk_d;
  assign pcm_ready = ~fifo_full;
  assign running   = (state == ST_RUN);

  pdm_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pcm_valid),
    .din   (pcm_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The edge that loads a sample also emits that sample's first bit.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    cur_next      = cur_sample;
    fifo_pop      = 1'b0;
    underrun_next = 1'b0;
    u             = PCM_OFFSET;
    if (mic_edge) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            cur_next     = fifo_dout;
            bit_cnt_next = '0;
            state_next   = ST_RUN;
            u            = fifo_dout ^ PCM_OFFSET;
          end
        end
        ST_RUN: begin
          if (bit_cnt == CW'(DECIM - 1)) begin
            bit_cnt_next = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              cur_next = fifo_dout;
              u        = fifo_dout ^ PCM_OFFSET;
            end else begin
              underrun_next = 1'b1;
              cur_next      = 16'h0000;
              state_next    = ST_IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + CW'(1);
            u            = cur_sample ^ PCM_OFFSET;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign sum = {1'b0, acc} + {1'b0, u};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      cur_sample  <= 16'h0000;
      acc         <= 16'h0000;
      mic_data    <= 1'b0;
      mic_data_oe <= 1'b0;
      mic_clk_d   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      mic_clk_d   <= mic_clk;
      mic_data_oe <= (mic_lr_sel == LR_CHANNEL);
      underrun    <= underrun_next;
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      cur_sample  <= cur_next;
      if (mic_edge) begin
        acc      <= sum[15:0];
        mic_data <= sum[16];
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_model.sv
// Self-checking bench for pdm_mic_model: per-sample bit-count vectors,
// backpressure/underrun/reset sequences and randomized pushes vs a model.
module tb_pdm_mic_model;

  localparam int DECIM = 128;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mic_clk = 1'b0;
  logic        mic_lr_sel = 1'b0;
  logic        mic_data;
  logic        mic_data_oe;
  logic        pcm_valid = 1'b0;
  logic [15:0] pcm_data = 16'h0000;
  logic        pcm_ready;
  logic        underrun;
  logic        running;

  int checks = 0;
  int errors = 0;

  pdm_mic_model #(
    .DECIM      (DECIM),
    .FIFO_DEPTH (DEPTH),
    .LR_CHANNEL (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mic_clk     (mic_clk),
    .mic_lr_sel  (mic_lr_sel),
    .mic_data    (mic_data),
    .mic_data_oe (mic_data_oe),
    .pcm_valid   (pcm_valid),
    .pcm_data    (pcm_data),
    .pcm_ready   (pcm_ready),
    .underrun    (underrun),
    .running     (running)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference: each queued sample occupies DECIM consecutive edges; with
  // nothing playing the modulator input is midscale.
  logic [15:0] m_q[$];
  logic [15:0] m_cur;
  int          m_acc;
  int          m_left;
  bit          m_active;

  bit last_bit;
  bit last_un;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_cur    = 16'h0000;
    m_acc    = 0;
    m_left   = 0;
    m_active = 1'b0;
  endfunction

  function automatic void model_edge(output bit b, output bit un);
    int u;
    un = 1'b0;
    if (m_active && m_left > 0) begin
      u = int'(m_cur ^ 16'h8000);
      m_left--;
    end else if (m_q.size() > 0) begin
      m_cur    = m_q.pop_front();
      u        = int'(m_cur ^ 16'h8000);
      m_left   = DECIM - 1;
      m_active = 1'b1;
    end else begin
      un       = m_active;
      m_active = 1'b0;
      u        = 32768;
    end
    m_acc = m_acc + u;
    b     = (m_acc >= 65536);
    m_acc = m_acc % 65536;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_edge(input int half);
    bit eb, eu;
    @(posedge clk);
    #1 mic_clk = 1'b1;
    @(posedge clk);
    #1;
    model_edge(eb, eu);
    chk("mic_data", mic_data, eb);
    chk("underrun", underrun, eu);
    chk("running", running, m_active);
    chk("pcm_ready", pcm_ready, m_q.size() < DEPTH);
    chk("mic_data_oe", mic_data_oe, (mic_lr_sel == 1'b0));
    last_bit = mic_data;
    last_un  = underrun;
    @(posedge clk);
    #1 chk("underrun_width", underrun, 1'b0);
    repeat (half - 2) begin
      @(posedge clk);
      #1;
    end
    mic_clk = 1'b0;
    repeat (half) @(posedge clk);
    #1 chk("mic_data_hold", mic_data, eb);
  endtask

  task automatic push_sample(input logic [15:0] s);
    chk("pcm_ready_pre", pcm_ready, m_q.size() < DEPTH);
    if (m_q.size() < DEPTH) begin
      pcm_valid = 1'b1;
      pcm_data  = s;
      @(posedge clk);
      #1 pcm_valid = 1'b0;
      m_q.push_back(s);
    end
  endtask

  typedef struct {
    logic [15:0] pcm;
    int          ones;
    bit          first;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   ones;
    bit   first;
    logic [15:0] s;

    vecs[0] = '{pcm: 16'h7FFF, ones: 127, first: 1'b0};
    vecs[1] = '{pcm: 16'h8000, ones: 0,   first: 1'b0};
    vecs[2] = '{pcm: 16'h4000, ones: 96,  first: 1'b0};
    vecs[3] = '{pcm: 16'h0000, ones: 64,  first: 1'b0};
    vecs[4] = '{pcm: 16'hC000, ones: 32,  first: 1'b0};

    model_reset();
    #2;
    chk("rst_mic_data", mic_data, 1'b0);
    chk("rst_oe", mic_data_oe, 1'b0);
    chk("rst_ready", pcm_ready, 1'b1);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_running", running, 1'b0);
    do_reset();

    // Idle at 2.5 MHz mic_clk: plain alternation, never running.
    for (int i = 0; i < 8; i++) begin
      do_edge(20);
      chk("idle_bit", last_bit, i % 2);
      chk("idle_running", running, 1'b0);
    end

    // One sample per vector, counted over its DECIM bits.
    foreach (vecs[k]) begin
      do_reset();
      push_sample(vecs[k].pcm);
      ones  = 0;
      first = 1'b0;
      for (int i = 0; i < DECIM; i++) begin
        do_edge(4);
        if (i == 0) first = last_bit;
        ones += int'(last_bit);
      end
      chk("vec_ones", ones, vecs[k].ones);
      chk("vec_first", first, vecs[k].first);
    end

    // Backpressure: fifth sample waits for the first pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_sample(16'(16'h1000 * (i + 1)));
    chk("bp_full", pcm_ready, 1'b0);
    pcm_valid = 1'b1;
    pcm_data  = 16'hA5A5;
    repeat (3) @(posedge clk);
    #1 chk("bp_still_full", pcm_ready, 1'b0);
    do_edge(4);
    pcm_valid = 1'b0;
    m_q.push_back(16'hA5A5);
    chk("bp_refilled", pcm_ready, 1'b0);
    for (int i = 1; i < 5 * DECIM; i++) do_edge(4);
    chk("bp_no_underrun_yet", running, 1'b1);

    // Underrun after the last sample, then back to alternation.
    do_edge(4);
    chk("underrun_seen", last_un, 1'b1);
    chk("underrun_idle", running, 1'b0);
    for (int i = 0; i < 6; i++) do_edge(4);

    // Randomized pushes against the reference.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 1) push_sample(16'($urandom));
      do_edge($urandom_range(2, 6));
    end

    // Async reset part-way through a sample, with a simultaneous push.
    do_reset();
    push_sample(16'h7FFF);
    for (int i = 0; i < 60; i++) do_edge(4);
    @(posedge clk);
    #2;
    pcm_valid = 1'b1;
    pcm_data  = 16'h1234;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_mic_data", mic_data, 1'b0);
    chk("mid_rst_oe", mic_data_oe, 1'b0);
    chk("mid_rst_ready", pcm_ready, 1'b1);
    chk("mid_rst_underrun", underrun, 1'b0);
    chk("mid_rst_running", running, 1'b0);
    @(posedge clk);
    #1 pcm_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Other channel: drive disabled, bitstream unchanged.
    mic_lr_sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_edge(4);
      chk("other_ch_bit", last_bit, i % 2);
      chk("other_ch_oe", mic_data_oe, 1'b0);
    end
    mic_lr_sel = 1'b0;
    s = 16'h2000;
    push_sample(s);
    for (int i = 0; i < 4; i++) do_edge(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
